gate_unit_seq: RTL and testbench

//  Parametrised, registered bitwise gate unit. Computes NOT/NOR/OR/AND/NAND/XOR/XNOR/PASS on

---
 rtl/gate_unit_seq.sv | 157 +++++++++++++++
 tb/tb_gate_unit_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_seq.sv
// gate_unit_seq: registered bitwise gate unit with valid/ready handshake.
// Single-beat ops produce f(a,b) one cycle after accept; accumulate bursts
// fold a stream of A operands left-to-right with the op captured on beat one.
module gate_unit_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             in_last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic [CNT_W-1:0] beats
);

   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_PASS = 3'b111;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic [2:0]       op_q,        op_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] y_q,         y_d;
   logic             zero_q,      zero_d;
   logic [CNT_W-1:0] beats_q,     beats_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic [WIDTH-1:0] single_res;
   logic [WIDTH-1:0] fold_res;
   logic [CNT_W-1:0] cnt_inc;

   // Gate function: x is the left operand, yv the right. NOT/PASS act on yv.
   function automatic logic [WIDTH-1:0] gate_f(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] yv);
      logic [WIDTH-1:0] r;
      case (f_op)
         3'b000:  r = ~yv;
         3'b001:  r = ~(x | yv);
         3'b010:  r = x | yv;
         3'b011:  r = x & yv;
         3'b100:  r = ~(x & yv);
         3'b101:  r = x ^ yv;
         3'b110:  r = ~(x ^ yv);
         default: r = yv;
      endcase
      return r;
   endfunction

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Single ops feed A as the unary operand for NOT/PASS; the fold always
   // uses the running accumulator on the left and the new beat on the right.
   assign single_res = gate_f(op, a, ((op == OP_NOT) || (op == OP_PASS)) ? a : b);
   assign fold_res   = gate_f(op_q, acc_q, a);
   assign cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

   // Next-state logic: output-register drain, single ops and burst folding.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      y_d         = y_q;
      zero_d      = zero_q;
      beats_d     = beats_q;
      out_valid_d = out_valid_q;

      // A completed transfer empties the output register; zero follows valid.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         zero_d      = 1'b0;
      end

      if (accept) begin
         case (state_q)
            IDLE: begin
               if (!acc_mode) begin
                  y_d         = single_res;
                  zero_d      = (single_res == '0);
                  beats_d     = CNT_ONE;
                  out_valid_d = 1'b1;
               end else if (in_last) begin
                  // One-beat burst: the fold of a single value is the value.
                  y_d         = a;
                  zero_d      = (a == '0);
                  beats_d     = CNT_ONE;
                  out_valid_d = 1'b1;
               end else begin
                  acc_d   = a;
                  op_d    = op;
                  cnt_d   = CNT_ONE;
                  state_d = ACC;
               end
            end
            default: begin
               if (in_last) begin
                  y_d         = fold_res;
                  zero_d      = (fold_res == '0);
                  beats_d     = cnt_inc;
                  out_valid_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  acc_d = fold_res;
                  cnt_d = cnt_inc;
               end
            end
         endcase
      end
   end

   // State and output registers; reset discards any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         y_q         <= '0;
         zero_q      <= 1'b0;
         beats_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         beats_q     <= beats_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign beats     = beats_q;

endmodule

// File: tb/tb_gate_unit_seq.sv
// Bench for gate_unit_seq: two instances (CNT_W=4 and CNT_W=2) share one
// input stream; a queue-based reference model predicts both.
module tb_gate_unit_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] op = 3'd0;
   logic       acc_mode = 1'b0;
   logic       in_last = 1'b0;
   logic [7:0] a = 8'd0;
   logic [7:0] b = 8'd0;
   logic       out_ready = 1'b0;

   logic       in_ready4, out_valid4, zero4;
   logic [7:0] y4;
   logic [3:0] beats4;
   logic       in_ready2, out_valid2, zero2;
   logic [7:0] y2;
   logic [1:0] beats2;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic       m_valid = 1'b0;
   logic [7:0] m_y = 8'd0;
   int         m_n = 0;
   logic       m_burst = 1'b0;
   logic [2:0] m_bop = 3'd0;
   logic [7:0] m_q[$];

   always #5 clk = ~clk;

   gate_unit_seq #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .op(op), .acc_mode(acc_mode), .in_last(in_last), .a(a), .b(b),
      .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .zero(zero4),
      .beats(beats4)
   );

   gate_unit_seq #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .op(op), .acc_mode(acc_mode), .in_last(in_last), .a(a), .b(b),
      .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .zero(zero2),
      .beats(beats2)
   );

   function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] v);
      case (o)
         3'd0: return ~v;
         3'd1: return ~(x | v);
         3'd2: return x | v;
         3'd3: return x & v;
         3'd4: return ~(x & v);
         3'd5: return x ^ v;
         3'd6: return ~(x ^ v);
         default: return v;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      int sat4, sat2;
      sat4 = (m_n > 15) ? 15 : m_n;
      sat2 = (m_n > 3) ? 3 : m_n;
      chk({tag, ".out_valid4"}, 32'(out_valid4), 32'(m_valid));
      chk({tag, ".y4"},         32'(y4),         32'(m_y));
      chk({tag, ".zero4"},      32'(zero4),      32'(m_valid && (m_y == 8'd0)));
      chk({tag, ".beats4"},     32'(beats4),     32'(sat4));
      chk({tag, ".out_valid2"}, 32'(out_valid2), 32'(m_valid));
      chk({tag, ".y2"},         32'(y2),         32'(m_y));
      chk({tag, ".zero2"},      32'(zero2),      32'(m_valid && (m_y == 8'd0)));
      chk({tag, ".beats2"},     32'(beats2),     32'(sat2));
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_y     = 8'd0;
      m_n     = 0;
      m_burst = 1'b0;
      m_bop   = 3'd0;
      m_q.delete();
   endtask

   // One clock of traffic: drive at negedge, check ready, advance model at posedge.
   task automatic step(input string tag, input logic v, input logic [2:0] o,
                       input logic am, input logic last, input logic [7:0] ia,
                       input logic [7:0] ib, input logic ordy);
      logic acc;
      logic [7:0] r;
      @(negedge clk);
      in_valid = v; op = o; acc_mode = am; in_last = last; a = ia; b = ib;
      out_ready = ordy;
      #1;
      chk({tag, ".in_ready4"}, 32'(in_ready4), 32'(!m_valid || ordy));
      chk({tag, ".in_ready2"}, 32'(in_ready2), 32'(!m_valid || ordy));
      @(posedge clk);
      acc = v && (!m_valid || ordy);
      if (m_valid && ordy) m_valid = 1'b0;
      if (acc) begin
         if (!m_burst) begin
            if (!am) begin
               m_y = ref_f(o, ia, (o == 3'd0 || o == 3'd7) ? ia : ib);
               m_n = 1; m_valid = 1'b1;
            end else if (last) begin
               m_y = ia; m_n = 1; m_valid = 1'b1;
            end else begin
               m_burst = 1'b1; m_bop = o; m_q.delete(); m_q.push_back(ia);
            end
         end else begin
            m_q.push_back(ia);
            if (last) begin
               r = m_q[0];
               for (int i = 1; i < m_q.size(); i++) r = ref_f(m_bop, r, m_q[i]);
               m_y = r; m_n = m_q.size(); m_valid = 1'b1;
               m_burst = 1'b0; m_q.delete();
            end
         end
      end
      #1;
      check_outputs(tag);
      $display("step %s v=%0b op=%0d am=%0b last=%0b a=%h b=%h ordy=%0b -> y=%h ov=%0b beats=%0d/%0d",
               tag, v, o, am, last, ia, ib, ordy, y4, out_valid4, beats4, beats2);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      #2;
      model_reset();
      check_outputs(tag);
      $display("reset %s", tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // T1: AND F0 & 3C = 30
      step("T1", 1, 3'd3, 0, 0, 8'hF0, 8'h3C, 1);
      chk("T1.y_const", 32'(y4), 32'h30);

      // T2: all ops back-to-back on A5 / 0F
      for (int k = 0; k < 8; k++) step("T2", 1, 3'(k), 0, 0, 8'hA5, 8'h0F, 1);
      chk("T2.pass_const", 32'(y4), 32'hA5);

      // T3: back-pressure then release
      step("T3a", 1, 3'd2, 0, 0, 8'h11, 8'h22, 0);
      step("T3b", 1, 3'd5, 0, 0, 8'h0F, 8'hFF, 0);
      step("T3c", 1, 3'd5, 0, 0, 8'h0F, 8'hFF, 1);
      chk("T3.y_const", 32'(y4), 32'hF0);
      step("T3d", 0, 3'd0, 0, 0, 8'h00, 8'h00, 1);

      // T4: XOR burst 01,02,04 -> 07, beats 3
      step("T4a", 1, 3'd5, 1, 0, 8'h01, 8'h00, 1);
      step("T4b", 1, 3'd0, 0, 0, 8'h02, 8'h00, 1);
      step("T4c", 1, 3'd0, 0, 1, 8'h04, 8'h00, 1);
      chk("T4.y_const", 32'(y4), 32'h07);
      chk("T4.beats_const", 32'(beats4), 32'd3);

      // T5: reset mid-burst, then OR 00|00 -> zero
      step("T5a", 1, 3'd3, 1, 0, 8'h33, 8'h00, 1);
      step("T5b", 1, 3'd3, 1, 0, 8'h44, 8'h00, 1);
      pulse_reset("T5rst");
      step("T5c", 0, 3'd0, 0, 1, 8'h55, 8'h00, 1);
      step("T5d", 1, 3'd2, 0, 0, 8'h00, 8'h00, 1);
      chk("T5.zero_const", 32'(zero4), 32'd1);

      // T6: five AND beats of FF; CNT_W=2 saturates at 3
      for (int k = 0; k < 5; k++) step("T6", 1, 3'd3, 1, (k == 4), 8'hFF, 8'h00, 1);
      chk("T6.beats2_const", 32'(beats2), 32'd3);
      chk("T6.beats4_const", 32'(beats4), 32'd5);

      // Single-beat burst (in_last on first accumulate beat)
      step("T7", 1, 3'd1, 1, 1, 8'h5C, 8'hFF, 1);

      // Long burst to saturate the 4-bit counter
      for (int k = 0; k < 18; k++) step("T8", 1, 3'd2, 1, (k == 17), 8'(k), 8'h00, 1);
      chk("T8.beats4_const", 32'(beats4), 32'd15);

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         step("rnd", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
         if (k == 200) pulse_reset("rnd_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
